// File: rtl/rle_block_encoder_pkg.sv
// Shared encoder definitions: pair layout, block geometry, EOB marker and FSM states.
// The downstream bitstream mux imports the same package so both sides agree on the pair format.
package rle_block_encoder_pkg;

   localparam int MAX_PAIRS = 64;
   localparam int COEFF_W   = 8;
   localparam int RUN_W     = 8;
   localparam int PAIR_W    = 16;
   localparam int BLOCK_W   = MAX_PAIRS * PAIR_W;
   localparam int CH_W      = 2;
   localparam int IDX_W     = 6;
   localparam int CNT_W     = 7;

   localparam int RUN_MSB = 15;
   localparam int RUN_LSB = 8;
   localparam int LVL_MSB = 7;
   localparam int LVL_LSB = 0;

   // A real pair always carries a nonzero level, so an all-zero pair can only mean end-of-block.
   localparam logic [PAIR_W-1:0] EOB_PAIR = 16'h0000;

   typedef enum logic [1:0] {
      S_SCAN = 2'd0,
      S_EMIT = 2'd1
   } state_e;

   function automatic logic [PAIR_W-1:0] make_pair(input logic [RUN_W-1:0]   run,
                                                   input logic [COEFF_W-1:0] lvl);
      logic [PAIR_W-1:0] p;
      p = '0;
      p[RUN_MSB:RUN_LSB] = run;
      p[LVL_MSB:LVL_LSB] = lvl;
      return p;
   endfunction

endpackage

// File: rtl/rle_block_encoder.sv
// Run-length encodes one 64-coefficient zig-zag block into {run,level} pairs and holds the
// packed result until the bitstream mux takes it.
module rle_block_encoder
   import rle_block_encoder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [COEFF_W-1:0]   coeff_in,
   input  logic                 coeff_valid,
   input  logic [CH_W-1:0]      coeff_channel,
   output logic                 coeff_ready,
   output logic [BLOCK_W-1:0]   rle_block,
   output logic                 rle_valid,
   output logic [CNT_W-1:0]     pair_count,
   output logic [CH_W-1:0]      rle_channel_id,
   input  logic                 rle_ready,
   output logic [1:0]           dbg_state
);

   // Handshakes: a coefficient moves when coeff_valid && coeff_ready on a rising clk edge;
   // a block moves when rle_valid && rle_ready && enable on a rising clk edge. rle_valid and
   // all block outputs stay stable from assertion until that edge.

   state_e              state_q, state_d;
   logic [BLOCK_W-1:0]  blk_q, blk_d;
   logic [CNT_W-1:0]    pair_cnt_q, pair_cnt_d;
   logic [RUN_W-1:0]    zero_run_q, zero_run_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CH_W-1:0]     chan_q, chan_d;

   logic                accept;
   logic                handoff;
   logic                last_coeff;
   logic                coeff_nz;
   logic [9:0]          slot_base;

   assign coeff_ready = (state_q == S_SCAN) && enable;
   assign accept      = coeff_valid && coeff_ready;
   assign rle_valid   = (state_q == S_EMIT);
   assign handoff     = rle_valid && rle_ready && enable;

   assign last_coeff  = (idx_q == IDX_W'(MAX_PAIRS - 1));
   assign coeff_nz    = (coeff_in != '0);
   // pair_cnt never exceeds 63 before a write, so its low 6 bits address the slot.
   assign slot_base   = {pair_cnt_q[IDX_W-1:0], 4'b0000};

   assign rle_block      = blk_q;
   assign pair_count     = pair_cnt_q;
   assign rle_channel_id = chan_q;
   assign dbg_state      = state_q;

   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      pair_cnt_d = pair_cnt_q;
      zero_run_d = zero_run_q;
      idx_d      = idx_q;
      chan_d     = chan_q;

      case (state_q)
         S_SCAN: begin
            if (accept) begin
               if (idx_q == '0) begin
                  chan_d = coeff_channel;
               end
               if (coeff_nz) begin
                  blk_d[slot_base +: PAIR_W] = make_pair(zero_run_q, coeff_in);
                  pair_cnt_d                 = pair_cnt_q + 7'd1;
                  zero_run_d                 = '0;
               end else begin
                  zero_run_d = zero_run_q + 8'd1;
               end
               if (last_coeff) begin
                  // A trailing zero leaves a pending run, which is closed by EOB in the
                  // slot the zero would otherwise have needed.
                  if (!coeff_nz) begin
                     blk_d[slot_base +: PAIR_W] = EOB_PAIR;
                     pair_cnt_d                 = pair_cnt_q + 7'd1;
                  end
                  state_d = S_EMIT;
               end
               idx_d = idx_q + 6'd1;
            end
         end
         S_EMIT: begin
            if (handoff) begin
               blk_d      = '0;
               pair_cnt_d = '0;
               zero_run_d = '0;
               idx_d      = '0;
               state_d    = S_SCAN;
            end
         end
         default: begin
            state_d = S_SCAN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_SCAN;
         blk_q      <= '0;
         pair_cnt_q <= '0;
         zero_run_q <= '0;
         idx_q      <= '0;
         chan_q     <= '0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         pair_cnt_q <= pair_cnt_d;
         zero_run_q <= zero_run_d;
         idx_q      <= idx_d;
         chan_q     <= chan_d;
      end
   end

endmodule
